// File: rtl/mem_bus_if.sv
// mem_bus_if -- MEM-stage memory access front end.
// Routes each access either to the scratch-pad memory (single cycle) or to
// the system bus (req/grant/strobe/ready handshake), stalling the pipeline
// via busy while a bus access is outstanding.
// Optional build macro: MEM_BUS_TIMEOUT_EN adds a ready timeout and bus_err.
module mem_bus_if #(
   parameter int unsigned       ADDR_W      = 30,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       PAGE_W      = 3,
   parameter logic [PAGE_W-1:0] SPM_PAGE    = 3'h1,
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] addr,
   input  logic              as_,
   input  logic              rw,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   input  logic [DATA_W-1:0] spm_rd_data,
   output logic [ADDR_W-1:0] spm_addr,
   output logic              spm_as_,
   output logic              spm_rw,
   output logic [DATA_W-1:0] spm_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_,
   input  logic              bus_grnt_,
   output logic              bus_req_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data
`ifdef MEM_BUS_TIMEOUT_EN
   ,
   output logic              bus_err
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2,
      STALL  = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              spm_hit;
   logic              bus_start;   // IDLE -> REQ: latch request, raise bus_req_
   logic              bus_strobe;  // REQ -> ACCESS: grant seen, strobe next cycle
   logic              bus_abort;   // REQ -> IDLE: flushed before grant
   logic              bus_done;    // ready seen in ACCESS
   logic [DATA_W-1:0] rd_buf;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 256) ? $clog2(TIMEOUT_CYC) : 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_hit;
`endif

   // SPM side is a straight pass-through apart from the gated strobe.
   assign spm_hit     = (addr[ADDR_W-1 -: PAGE_W] == SPM_PAGE);
   assign spm_addr    = addr;
   assign spm_rw      = rw;
   assign spm_wr_data = wr_data;
   assign spm_as_     = ~((state == IDLE) && !as_ && spm_hit && !flush);

   // Next-state decode, combinational read data and busy.
   always_comb begin
      next_state = state;
      rd_data    = '0;
      busy       = 1'b0;
      bus_start  = 1'b0;
      bus_strobe = 1'b0;
      bus_abort  = 1'b0;
      bus_done   = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_hit    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!as_ && !flush) begin
               if (spm_hit) begin
                  rd_data = rw ? spm_rd_data : '0;
               end else begin
                  busy       = 1'b1;
                  bus_start  = 1'b1;
                  next_state = REQ;
               end
            end
         end
         REQ: begin
            busy = 1'b1;
            // Grant takes priority over a flush arriving in the same cycle.
            if (!bus_grnt_) begin
               bus_strobe = 1'b1;
               next_state = ACCESS;
            end else if (flush) begin
               bus_abort  = 1'b1;
               next_state = IDLE;
            end
         end
         ACCESS: begin
            // A strobed access always completes; flush is not looked at here.
            if (!bus_rdy_) begin
               bus_done   = 1'b1;
               rd_data    = bus_rw ? bus_rd_data : '0;
               next_state = stall ? STALL : IDLE;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               tmo_hit    = 1'b1;
               next_state = stall ? STALL : IDLE;
            end
`endif
            else begin
               busy = 1'b1;
            end
         end
         STALL: begin
            rd_data = rd_buf;
            if (!stall) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Registered bus-side outputs and the held read result.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_req_    <= 1'b1;
         bus_as_     <= 1'b1;
         bus_rw      <= 1'b1;
         bus_addr    <= '0;
         bus_wr_data <= '0;
         rd_buf      <= '0;
      end else begin
         // Strobe is low only in the cycle after the grant, i.e. the first ACCESS cycle.
         bus_as_ <= ~bus_strobe;
         if (bus_start) begin
            bus_req_    <= 1'b0;
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
         end
         if (bus_abort || bus_done) bus_req_ <= 1'b1;
         if (bus_done) rd_buf <= bus_rd_data;
`ifdef MEM_BUS_TIMEOUT_EN
         if (tmo_hit) begin
            bus_req_ <= 1'b1;
            rd_buf   <= '0;
         end
`endif
      end
   end

`ifdef MEM_BUS_TIMEOUT_EN
   // Ready timeout counter, restarted whenever an access is strobed; bus_err pulses once.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= tmo_hit;
         if (bus_strobe) tmo_cnt <= '0;
         else if ((state == ACCESS) && bus_rdy_) tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if -- directed vector bench for mem_bus_if.
// Inputs are driven at the falling edge, outputs sampled 1 ns later.
// Define MEM_BUS_TIMEOUT_EN to also exercise the ready timeout (TIMEOUT_CYC = 8).
module tb_mem_bus_if;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int unsigned TB_TMO = 8;
`else
   localparam int unsigned TB_TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset, stall, flush, as_, rw;
   logic [29:0] addr;
   logic [31:0] wr_data, spm_rd_data, bus_rd_data;
   logic        bus_rdy_, bus_grnt_;
   logic [31:0] rd_data, spm_wr_data, bus_wr_data;
   logic [29:0] spm_addr, bus_addr;
   logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
`ifdef MEM_BUS_TIMEOUT_EN
   logic        bus_err;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   mem_bus_if #(
      .ADDR_W      (30),
      .DATA_W      (32),
      .PAGE_W      (3),
      .SPM_PAGE    (3'h1),
      .TIMEOUT_CYC (TB_TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .addr        (addr),
      .as_         (as_),
      .rw          (rw),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .busy        (busy),
      .spm_rd_data (spm_rd_data),
      .spm_addr    (spm_addr),
      .spm_as_     (spm_as_),
      .spm_rw      (spm_rw),
      .spm_wr_data (spm_wr_data),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_),
      .bus_grnt_   (bus_grnt_),
      .bus_req_    (bus_req_),
      .bus_addr    (bus_addr),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_wr_data (bus_wr_data)
`ifdef MEM_BUS_TIMEOUT_EN
      ,
      .bus_err     (bus_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        as_n;
      logic        rw;
      logic        flush;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] spm_rd;
      logic [31:0] exp_rd;
      logic        exp_busy;
      logic        exp_spm_as_n;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stall       = 1'b0;
      flush       = 1'b0;
      as_         = 1'b1;
      rw          = 1'b1;
      addr        = '0;
      wr_data     = '0;
      spm_rd_data = '0;
      bus_rd_data = '0;
      bus_rdy_    = 1'b1;
      bus_grnt_   = 1'b1;
   endtask

   // One-cycle SPM read used to prove the FSM is back in IDLE.
   task automatic spm_probe(input string name, input logic [31:0] data);
      @(negedge clk);
      idle_inputs();
      as_         = 1'b0;
      addr        = 30'h0800_0044;
      spm_rd_data = data;
      #1;
      chk({name, " rd_data"}, rd_data, data);
      chk({name, " spm_as_"}, {31'd0, spm_as_}, 32'd0);
      chk({name, " busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int unsigned nbusy, nas, nacc;
      bit          done;

      // IDLE-state vectors: SPM hits, idle cycles, flushed starts, page boundaries.
      vt[0] = '{1'b1, 1'b1, 1'b0, 30'h0800_0010, 32'h0000_0000, 32'hCAFE_0001, 32'h0000_0000, 1'b0, 1'b1};
      vt[1] = '{1'b0, 1'b1, 1'b0, 30'h0800_0010, 32'h0000_0000, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b0, 30'h0800_0020, 32'h7777_0001, 32'hCAFE_0002, 32'h0000_0000, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b1, 30'h0800_0010, 32'h0000_0000, 32'hCAFE_0003, 32'h0000_0000, 1'b0, 1'b1};
      vt[4] = '{1'b0, 1'b1, 1'b0, 30'h0FFF_FFFF, 32'h0000_0000, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b0, 30'h0800_0000, 32'h0000_0000, 32'h0246_8ACE, 32'h0246_8ACE, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b1, 1'b1, 30'h07FF_FFFF, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1};
      vt[7] = '{1'b1, 1'b1, 1'b0, 30'h1000_0000, 32'h0000_0000, 32'h2222_2222, 32'h0000_0000, 1'b0, 1'b1};

      // Reset values.
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst bus_req_", {31'd0, bus_req_}, 32'd1);
      chk("rst bus_as_", {31'd0, bus_as_}, 32'd1);
      chk("rst bus_rw", {31'd0, bus_rw}, 32'd1);
      chk("rst bus_addr", {2'b0, bus_addr}, 32'd0);
      chk("rst bus_wr_data", bus_wr_data, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst rd_data", rd_data, 32'd0);
`ifdef MEM_BUS_TIMEOUT_EN
      chk("rst bus_err", {31'd0, bus_err}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Table-driven IDLE vectors.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle_inputs();
         as_         = vt[i].as_n;
         rw          = vt[i].rw;
         flush       = vt[i].flush;
         addr        = vt[i].addr;
         wr_data     = vt[i].wdata;
         spm_rd_data = vt[i].spm_rd;
         #1;
         chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].exp_rd);
         chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vt[i].exp_busy});
         chk($sformatf("vec%0d spm_as_", i), {31'd0, spm_as_}, {31'd0, vt[i].exp_spm_as_n});
         chk($sformatf("vec%0d spm_addr", i), {2'b0, spm_addr}, {2'b0, vt[i].addr});
         chk($sformatf("vec%0d spm_rw", i), {31'd0, spm_rw}, {31'd0, vt[i].rw});
         chk($sformatf("vec%0d spm_wr_data", i), spm_wr_data, vt[i].wdata);
         chk($sformatf("vec%0d bus_req_", i), {31'd0, bus_req_}, 32'd1);
      end

      // Bus read to 0x40: grant in cycle 2, ready in cycle 5.
      nbusy = 0;
      nas   = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         idle_inputs();
         as_         = (c < 6) ? 1'b0 : 1'b1;
         addr        = 30'h0000_0040;
         bus_grnt_   = (c >= 2 && c < 6) ? 1'b0 : 1'b1;
         bus_rdy_    = (c == 5) ? 1'b0 : 1'b1;
         bus_rd_data = (c == 5) ? 32'h1234_5678 : 32'hFFFF_FFFF;
         #1;
         if (busy) nbusy++;
         if (!bus_as_) nas++;
         if (c == 1) begin
            chk("rdA bus_req_ low", {31'd0, bus_req_}, 32'd0);
            chk("rdA bus_addr", {2'b0, bus_addr}, 32'h0000_0040);
            chk("rdA bus_rw", {31'd0, bus_rw}, 32'd1);
         end
         if (c == 4) chk("rdA rd_data while busy", rd_data, 32'd0);
         if (c == 5) chk("rdA rd_data at ready", rd_data, 32'h1234_5678);
      end
      chk("rdA busy cycles", nbusy, 32'd5);
      chk("rdA strobe cycles", nas, 32'd1);
      chk("rdA bus_req_ released", {31'd0, bus_req_}, 32'd1);

      // Bus write flushed while waiting for grant.
      nas = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle_inputs();
         as_     = (c < 2) ? 1'b0 : 1'b1;
         rw      = 1'b0;
         addr    = 30'h0000_0080;
         wr_data = 32'h0000_A5A5;
         flush   = (c == 1);
         #1;
         if (!bus_as_) nas++;
         if (c == 1) begin
            chk("wrF bus_rw", {31'd0, bus_rw}, 32'd0);
            chk("wrF bus_wr_data", bus_wr_data, 32'h0000_A5A5);
            chk("wrF busy in REQ", {31'd0, busy}, 32'd1);
         end
         if (c == 2) begin
            chk("wrF bus_req_ back", {31'd0, bus_req_}, 32'd1);
            chk("wrF busy", {31'd0, busy}, 32'd0);
         end
      end
      chk("wrF strobe never", nas, 32'd0);
      spm_probe("wrF idle", 32'h0BAD_0001);

      // Grant and flush together: grant wins; then a write completes, flush ignored.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle_inputs();
         as_         = (c < 3) ? 1'b0 : 1'b1;
         rw          = 1'b0;
         addr        = 30'h0000_0200;
         wr_data     = 32'h0BAD_F00D;
         bus_grnt_   = (c == 1 || c == 2) ? 1'b0 : 1'b1;
         flush       = (c == 1 || c == 2);
         bus_rdy_    = (c == 2) ? 1'b0 : 1'b1;
         bus_rd_data = 32'h5555_5555;
         #1;
         if (c == 2) begin
            chk("gw strobe", {31'd0, bus_as_}, 32'd0);
            chk("gw busy at ready", {31'd0, busy}, 32'd0);
            chk("gw rd_data write", rd_data, 32'd0);
            chk("gw bus_wr_data", bus_wr_data, 32'h0BAD_F00D);
         end
         if (c == 3) chk("gw bus_req_", {31'd0, bus_req_}, 32'd1);
      end

      // Minimum-latency read completing under stall, held through STALL.
      nbusy = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle_inputs();
         as_         = (c < 3) ? 1'b0 : 1'b1;
         addr        = 30'h0000_0100;
         bus_grnt_   = (c == 1 || c == 2) ? 1'b0 : 1'b1;
         bus_rdy_    = (c == 2) ? 1'b0 : 1'b1;
         bus_rd_data = (c == 2) ? 32'hDEAD_BEEF : 32'h0000_0000;
         stall       = (c >= 2 && c <= 5);
         #1;
         if (busy) nbusy++;
         if (c >= 2 && c <= 6) begin
            chk($sformatf("st rd_data c%0d", c), rd_data, 32'hDEAD_BEEF);
            chk($sformatf("st busy c%0d", c), {31'd0, busy}, 32'd0);
         end
         if (c == 7) chk("st rd_data after", rd_data, 32'd0);
      end
      chk("st min busy cycles", nbusy, 32'd2);
      spm_probe("st idle", 32'h0BAD_0002);

      // Reset while in ACCESS.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_inputs();
         as_       = (c < 3) ? 1'b0 : 1'b1;
         addr      = 30'h0000_0300;
         bus_grnt_ = (c == 1) ? 1'b0 : 1'b1;
         reset     = (c == 3);
         #1;
         if (c == 3) chk("rstA busy in ACCESS", {31'd0, busy}, 32'd1);
         if (c == 4) begin
            chk("rstA bus_req_", {31'd0, bus_req_}, 32'd1);
            chk("rstA bus_as_", {31'd0, bus_as_}, 32'd1);
            chk("rstA busy", {31'd0, busy}, 32'd0);
            chk("rstA bus_addr", {2'b0, bus_addr}, 32'd0);
         end
      end
      spm_probe("rstA idle", 32'h0BAD_0003);

`ifdef MEM_BUS_TIMEOUT_EN
      // Ready never arrives: forced completion in the 8th ACCESS cycle.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         idle_inputs();
         as_       = 1'b0;
         addr      = 30'h0000_0400;
         bus_grnt_ = (c == 1) ? 1'b0 : 1'b1;
      end
      nacc = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         idle_inputs();
         as_         = 1'b0;
         addr        = 30'h0000_0400;
         bus_rd_data = 32'h9999_9999;
         #1;
         nacc++;
         if (!busy) begin
            done = 1'b1;
            chk("tmo rd_data", rd_data, 32'd0);
            chk("tmo bus_err early", {31'd0, bus_err}, 32'd0);
         end
      end
      chk("tmo completed", {31'd0, done}, 32'd1);
      chk("tmo access cycles", nacc, 32'd8);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("tmo bus_err pulse", {31'd0, bus_err}, 32'd1);
      chk("tmo bus_req_", {31'd0, bus_req_}, 32'd1);
      @(negedge clk);
      #1;
      chk("tmo bus_err one cycle", {31'd0, bus_err}, 32'd0);
`else
      nacc = 0;
      done = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
